// File: rtl/lcd_spi_arbiter.sv
// Burst arbiter sharing the ILI9341 SPI byte engine between the command sequencer (port 0) and the pixel stream (port 1).
// Build option: define LCD_ARB_PRIO_EN so that port 0 wins every tie (round-robin otherwise).
module lcd_spi_arbiter #(
  parameter int GAP_CYC     = 8,
  parameter int TIMEOUT_CYC = 5_000_000
) (
  input  logic       clk,
  input  logic       btnC,
  input  logic       r0_valid,
  input  logic [7:0] r0_data,
  input  logic       r0_dc,
  input  logic       r0_last,
  output logic       r0_ready,
  input  logic       r1_valid,
  input  logic [7:0] r1_data,
  input  logic       r1_dc,
  input  logic       r1_last,
  output logic       r1_ready,
  output logic       spi_valid,
  output logic [7:0] spi_data,
  output logic       spi_dc,
  input  logic       spi_ready,
  output logic       lcd_cs_hold,
  output logic [1:0] grant,
  output logic       timeout_pulse
);

  localparam int TO_BITS = $clog2(TIMEOUT_CYC + 1);
  localparam int CNT_W   = (TO_BITS > 24) ? TO_BITS : 24;
  localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             done_q, done_d;
  logic             rr_last_q, rr_last_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             spi_valid_q, spi_valid_d;
  logic [7:0]       spi_data_q, spi_data_d;
  logic             spi_dc_q, spi_dc_d;

  logic       owning;
  logic       own_sel;
  logic       own_valid;
  logic [7:0] own_data;
  logic       own_dc;
  logic       own_last;
  logic       can_load;
  logic       accept;
  logic       tie_to_r1;

`ifdef LCD_ARB_PRIO_EN
  assign tie_to_r1 = 1'b0;
`else
  assign tie_to_r1 = !rr_last_q;
`endif

  // The output register can take a new byte when empty or when it drains this cycle.
  always_comb begin
    owning    = (state_q == ST_OWN0) || (state_q == ST_OWN1);
    own_sel   = (state_q == ST_OWN1);
    own_valid = own_sel ? r1_valid : r0_valid;
    own_data  = own_sel ? r1_data  : r0_data;
    own_dc    = own_sel ? r1_dc    : r0_dc;
    own_last  = own_sel ? r1_last  : r0_last;
    can_load  = !spi_valid_q || spi_ready;
    accept    = owning && !done_q && own_valid && can_load;
  end

  always_comb begin
    state_d       = state_q;
    done_d        = done_q;
    rr_last_d     = rr_last_q;
    idle_cnt_d    = idle_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    r0_ready      = 1'b0;
    r1_ready      = 1'b0;
    lcd_cs_hold   = 1'b0;
    grant         = 2'b00;
    timeout_pulse = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        idle_cnt_d = '0;
        done_d     = 1'b0;
        if (r0_valid && r1_valid) begin
          state_d = tie_to_r1 ? ST_OWN1 : ST_OWN0;
        end else if (r0_valid) begin
          state_d = ST_OWN0;
        end else if (r1_valid) begin
          state_d = ST_OWN1;
        end
      end
      ST_OWN0, ST_OWN1: begin
        lcd_cs_hold = 1'b1;
        grant       = own_sel ? 2'b10 : 2'b01;
        r0_ready    = !own_sel && !done_q && can_load;
        r1_ready    = own_sel && !done_q && can_load;
        // After the last byte, CS stays low until the engine has taken it.
        if (done_q) begin
          if (can_load) begin
            state_d   = ST_GAP;
            gap_cnt_d = '0;
            done_d    = 1'b0;
          end
        end else if (own_valid) begin
          idle_cnt_d = '0;
          if (accept && own_last) begin
            done_d    = 1'b1;
            rr_last_d = own_sel;
          end
        end else if (idle_cnt_q >= TO_LAST) begin
          timeout_pulse = 1'b1;
          rr_last_d     = own_sel;
          state_d       = ST_GAP;
          gap_cnt_d     = '0;
        end else if (idle_cnt_q != '1) begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    spi_valid_d = spi_valid_q;
    spi_data_d  = spi_data_q;
    spi_dc_d    = spi_dc_q;
    if (accept) begin
      spi_valid_d = 1'b1;
      spi_data_d  = own_data;
      spi_dc_d    = own_dc;
    end else if (spi_ready) begin
      spi_valid_d = 1'b0;
    end
  end

  // rr_last resets to 1 so that port 0 wins the first tie.
  always_ff @(posedge clk or negedge btnC) begin
    if (!btnC) begin
      state_q     <= ST_IDLE;
      done_q      <= 1'b0;
      rr_last_q   <= 1'b1;
      idle_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      spi_valid_q <= 1'b0;
      spi_data_q  <= 8'h00;
      spi_dc_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      rr_last_q   <= rr_last_d;
      idle_cnt_q  <= idle_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      spi_valid_q <= spi_valid_d;
      spi_data_q  <= spi_data_d;
      spi_dc_q    <= spi_dc_d;
    end
  end

  assign spi_valid = spi_valid_q;
  assign spi_data  = spi_data_q;
  assign spi_dc    = spi_dc_q;

endmodule

// File: tb/tb_lcd_spi_arbiter.sv
// Randomized and directed bench for lcd_spi_arbiter against a transaction-level arbitration/scoreboard model.
module tb_lcd_spi_arbiter;
  localparam int GAP = 8;
  localparam int TO  = 100;

  logic       clk = 1'b0;
  logic       btnC;
  logic       r0_valid, r0_dc, r0_last, r0_ready;
  logic [7:0] r0_data;
  logic       r1_valid, r1_dc, r1_last, r1_ready;
  logic [7:0] r1_data;
  logic       spi_valid, spi_dc, spi_ready;
  logic [7:0] spi_data;
  logic       lcd_cs_hold, timeout_pulse;
  logic [1:0] grant;

  always #5 clk = ~clk;

  lcd_spi_arbiter #(.GAP_CYC(GAP), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .btnC(btnC),
    .r0_valid(r0_valid), .r0_data(r0_data), .r0_dc(r0_dc), .r0_last(r0_last), .r0_ready(r0_ready),
    .r1_valid(r1_valid), .r1_data(r1_data), .r1_dc(r1_dc), .r1_last(r1_last), .r1_ready(r1_ready),
    .spi_valid(spi_valid), .spi_data(spi_data), .spi_dc(spi_dc), .spi_ready(spi_ready),
    .lcd_cs_hold(lcd_cs_hold), .grant(grant), .timeout_pulse(timeout_pulse)
  );

  typedef struct packed {
    logic [15:0] bub;
    logic        last;
    logic        dc;
    logic [7:0]  d;
  } ent_t;

  ent_t       q0[$], q1[$];
  logic [8:0] exp_q[$];
  logic [8:0] out_log[$];
  int         owner_log[$];
  int         n_checks = 0, n_err = 0;
  bit         loaded0, loaded1, acc0, acc1;
  int         bub0, bub1, rdy_mode;

  // Abstract model state: last served port, burst completion, stall run, gap run.
  int         last_served, noval, gap_len, to_count;
  bit         done, had_owner, pend_all;
  logic [1:0] prev_grant;
  bit         prev_v0, prev_v1, prev_sv, prev_sr, prev_to, prev_dc;
  logic [7:0] prev_d;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=0x%0h expected=0x%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(bit v0, bit v1, int ls);
    if (v0 && v1) begin
`ifdef LCD_ARB_PRIO_EN
      return (ls > 9) ? 0 : 0;
`else
      return (ls == 0) ? 1 : 0;
`endif
    end
    return v0 ? 0 : 1;
  endfunction

  task automatic model_clear();
    last_served = 1; noval = 0; gap_len = 0; done = 0; had_owner = 0; pend_all = 0;
    prev_grant = 2'b00; prev_v0 = 0; prev_v1 = 0; prev_sv = 0; prev_sr = 0; prev_to = 0;
    prev_dc = 0; prev_d = 8'h00;
  endtask

  task automatic monitor();
    int own;
    bit v0, v1, can, cur_to;
    v0 = r0_valid; v1 = r1_valid;
    acc0 = r0_valid && r0_ready;
    acc1 = r1_valid && r1_ready;
    check_eq("grant_onehot", grant == 2'b11, 0);
    check_eq("cs_hold", lcd_cs_hold, grant != 2'b00);
    if (prev_grant == 2'b00 && grant != 2'b00) begin
      own = grant[1] ? 1 : 0;
      check_eq("winner", own, pick(prev_v0, prev_v1, last_served));
      if (had_owner) begin
        check_eq("gap_min", gap_len >= GAP, 1);
        if (pend_all) check_eq("gap_max", gap_len <= GAP + 1, 1);
      end
      owner_log.push_back(own);
      done = 0; noval = 0;
    end
    if (prev_grant != 2'b00 && grant == 2'b00) begin
      check_eq("release_cause", done || prev_to, 1);
      had_owner = 1; gap_len = 0; pend_all = 1;
    end
    if (grant == 2'b00) begin
      gap_len++;
      pend_all = pend_all && (v0 || v1);
      check_eq("gap_spi_idle", spi_valid, 0);
    end
    can = !spi_valid || spi_ready;
    check_eq("r0_ready", r0_ready, grant[0] && !done && can);
    check_eq("r1_ready", r1_ready, grant[1] && !done && can);
    cur_to = 0;
    own = grant[1] ? 1 : 0;
    if (grant != 2'b00 && !done) begin
      if (own == 1 ? v1 : v0) noval = 0;
      else begin
        noval++;
        if (noval == TO) cur_to = 1;
      end
    end
    check_eq("timeout_pulse", timeout_pulse, cur_to);
    if (cur_to) begin last_served = own; to_count++; end
    if (prev_sv && !prev_sr) begin
      check_eq("hold_valid", spi_valid, 1);
      check_eq("hold_byte", {spi_dc, spi_data}, {prev_dc, prev_d});
    end
    if (spi_valid && spi_ready) begin
      check_eq("sb_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check_eq("spi_byte", {spi_dc, spi_data}, exp_q.pop_front());
      out_log.push_back({spi_dc, spi_data});
    end
    if (acc0) begin
      exp_q.push_back({r0_dc, r0_data});
      if (r0_last) begin done = 1; last_served = 0; end
    end
    if (acc1) begin
      exp_q.push_back({r1_dc, r1_data});
      if (r1_last) begin done = 1; last_served = 1; end
    end
    prev_grant = grant; prev_v0 = v0; prev_v1 = v1; prev_sv = spi_valid; prev_sr = spi_ready;
    prev_to = timeout_pulse; prev_dc = spi_dc; prev_d = spi_data;
  endtask

  task automatic drive();
    if (acc0) begin void'(q0.pop_front()); loaded0 = 0; end
    if (acc1) begin void'(q1.pop_front()); loaded1 = 0; end
    acc0 = 0; acc1 = 0;
    if (!loaded0 && q0.size() != 0) begin loaded0 = 1; bub0 = int'(q0[0].bub); end
    if (!loaded1 && q1.size() != 0) begin loaded1 = 1; bub1 = int'(q1[0].bub); end
    r0_valid = 0; r0_data = 8'($urandom); r0_last = 1'($urandom);
    r1_valid = 0; r1_data = 8'($urandom); r1_last = 1'($urandom);
    if (loaded0) begin
      if (bub0 > 0) bub0--;
      else begin r0_valid = 1; r0_data = q0[0].d; r0_dc = q0[0].dc; r0_last = q0[0].last; end
    end
    if (loaded1) begin
      if (bub1 > 0) bub1--;
      else begin r1_valid = 1; r1_data = q1[0].d; r1_dc = q1[0].dc; r1_last = q1[0].last; end
    end
    case (rdy_mode)
      0:       spi_ready = 1'b1;
      1:       spi_ready = ($urandom_range(0, 3) != 0);
      default: spi_ready = 1'b0;
    endcase
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic push(input int port, input logic [7:0] d, input logic dc, input logic last, input int bub);
    ent_t e;
    e.d = d; e.dc = dc; e.last = last; e.bub = 16'(bub);
    if (port == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic push_burst(input int port, input int len, input logic [7:0] base, input int bub);
    for (int j = 0; j < len; j++)
      push(port, 8'(base + j), (port == 1) || (j != 0), j == len - 1, (j == 0) ? bub : 0);
  endtask

  task automatic do_reset();
    btnC = 1'b0;
    #1;
    check_eq("rst_spi", {spi_valid, spi_dc, spi_data}, 0);
    check_eq("rst_ctl", {lcd_cs_hold, grant, r0_ready, r1_ready, timeout_pulse}, 0);
    q0.delete(); q1.delete(); exp_q.delete();
    loaded0 = 0; loaded1 = 0; acc0 = 0; acc1 = 0;
    r0_valid = 0; r1_valid = 0;
    model_clear();
    @(posedge clk); #1;
    @(posedge clk); #2;
    btnC = 1'b1;
  endtask

  task automatic run_until_idle(input int budget);
    int k = 0;
    while ((q0.size() != 0 || q1.size() != 0 || exp_q.size() != 0 || grant != 2'b00 ||
            spi_valid || r0_valid || r1_valid) && k < budget) begin
      cycle();
      k++;
    end
    check_eq("drain_left", q0.size() + q1.size() + exp_q.size(), 0);
    repeat (GAP + 3) cycle();
  endtask

  task automatic clear_logs();
    out_log.delete();
    owner_log.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    logic [8:0] t2e [5];
    int         t3e [4];
    int         to0;
    logic [8:0] e;
    btnC = 1'b1; rdy_mode = 0; spi_ready = 1'b1;
    r0_valid = 0; r0_data = 0; r0_dc = 0; r0_last = 0;
    r1_valid = 0; r1_data = 0; r1_dc = 0; r1_last = 0;
    to_count = 0; bub0 = 0; bub1 = 0;
    model_clear();
    #2;
    do_reset();

    // Single command burst, engine always ready
    clear_logs();
    push(0, 8'h2A, 0, 0, 0); push(0, 8'h00, 1, 0, 0); push(0, 8'h00, 1, 0, 0);
    push(0, 8'h00, 1, 0, 0); push(0, 8'hEF, 1, 1, 0);
    run_until_idle(200);
    t2e = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h1EF};
    check_eq("t2_count", out_log.size(), 5);
    for (int i = 0; i < 5 && i < out_log.size(); i++) check_eq("t2_byte", out_log[i], t2e[i]);
    check_eq("t2_owner", owner_log.size() == 1 && owner_log[0] == 0, 1);

    // Both ports pending from reset
    do_reset();
    clear_logs();
    push_burst(0, 3, 8'h10, 0); push_burst(0, 2, 8'h20, 0);
    push_burst(1, 3, 8'h30, 0); push_burst(1, 2, 8'h40, 0);
    run_until_idle(400);
`ifdef LCD_ARB_PRIO_EN
    t3e = '{0, 0, 1, 1};
`else
    t3e = '{0, 1, 0, 1};
`endif
    check_eq("t3_owners", owner_log.size(), 4);
    for (int i = 0; i < 4 && i < owner_log.size(); i++) check_eq("t3_order", owner_log[i], t3e[i]);
    check_eq("t3_bytes", out_log.size(), 10);

    // Engine stall mid-burst
    clear_logs();
    push_burst(0, 10, 8'h40, 0);
    repeat (5) cycle();
    rdy_mode = 2;
    repeat (20) cycle();
    rdy_mode = 0;
    run_until_idle(300);
    check_eq("t4_count", out_log.size(), 10);
    for (int i = 0; i < 10 && i < out_log.size(); i++) begin
      e = {(i != 0), 8'(8'h40 + i)};
      check_eq("t4_byte", out_log[i], e);
    end

    // Pixel owner stalls past the timeout while commands wait
    clear_logs();
    to0 = to_count;
    push(1, 8'h11, 1, 0, 0); push(1, 8'h12, 1, 0, 0); push(1, 8'h13, 1, 1, 150);
    push_burst(0, 2, 8'h2C, 5);
    run_until_idle(800);
    check_eq("t5_timeouts", to_count - to0, 1);
    check_eq("t5_owners", owner_log.size(), 3);
    if (owner_log.size() == 3)
      check_eq("t5_order", {owner_log[0][1:0], owner_log[1][1:0], owner_log[2][1:0]}, 6'b01_00_01);
    check_eq("t5_bytes", out_log.size(), 5);

    // Reset in the middle of a burst after port 0 was last served
    push_burst(0, 2, 8'h50, 0);
    run_until_idle(200);
    push_burst(0, 10, 8'h60, 0);
    repeat (4) cycle();
    do_reset();
    clear_logs();
    push_burst(0, 2, 8'h70, 0);
    push_burst(1, 2, 8'h80, 0);
    run_until_idle(200);
    check_eq("t6_owners", owner_log.size(), 2);
    if (owner_log.size() > 0) check_eq("t6_first", owner_log[0], 0);

    // Random traffic on both ports with a jittery engine
    clear_logs();
    rdy_mode = 1;
    for (int p = 0; p < 2; p++) begin
      for (int b = 0; b < 30; b++) begin
        int len;
        len = $urandom_range(1, 6);
        for (int j = 0; j < len; j++) begin
          int bb;
          if (j == 0) bb = $urandom_range(0, 4);
          else bb = ($urandom_range(0, 39) == 0) ? 120 : $urandom_range(0, 2);
          push(p, 8'($urandom), (p == 1) ? 1'b1 : 1'($urandom), j == len - 1, bb);
        end
      end
    end
    run_until_idle(20000);
    rdy_mode = 0;
    repeat (4) cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
